// File: rtl/bicubic_vreduce_stage2.sv
// Vertical reduction stage of the bicubic upscaler: weights four row inner products by a
// phase coefficient set, rounds and clamps to one channel value, buffers it in a credit-managed FIFO.
module bicubic_vreduce_stage2 #(
    parameter int CHANNEL_WIDTH       = 8,
    parameter int INTER_PRODUCT_WIDTH = 24,
    parameter int FRAC_BITS           = 14,
    parameter int OUT_DEPTH           = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [2:0]                            w_code,
    input  logic signed [INTER_PRODUCT_WIDTH-1:0] inner_product1,
    input  logic signed [INTER_PRODUCT_WIDTH-1:0] inner_product2,
    input  logic signed [INTER_PRODUCT_WIDTH-1:0] inner_product3,
    input  logic signed [INTER_PRODUCT_WIDTH-1:0] inner_product4,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [CHANNEL_WIDTH-1:0]              out_data
);

    localparam int PW    = INTER_PRODUCT_WIDTH + 8;
    localparam int SW    = INTER_PRODUCT_WIDTH + 10;
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MAXV  = (1 << CHANNEL_WIDTH) - 1;

    function automatic logic [CHANNEL_WIDTH-1:0] round_clamp(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] r;
        r = (s + SW'(1 <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
        if (r < 0)
            return '0;
        else if (r > SW'(MAXV))
            return CHANNEL_WIDTH'(MAXV);
        else
            return CHANNEL_WIDTH'(r);
    endfunction

    // Coefficients need 9 signed bits because the centre tap reaches +128.
    logic signed [8:0] c1, c2, c3, c4;
    always_comb begin
        c1 = 9'sd0;
        c2 = 9'sd128;
        c3 = 9'sd0;
        c4 = 9'sd0;
        case (w_code)
            3'd1: begin c1 = -9'sd9; c2 = 9'sd111; c3 = 9'sd29;  c4 = -9'sd3; end
            3'd2: begin c1 = -9'sd8; c2 = 9'sd72;  c3 = 9'sd72;  c4 = -9'sd8; end
            3'd3: begin c1 = -9'sd3; c2 = 9'sd29;  c3 = 9'sd111; c4 = -9'sd9; end
            default: ;
        endcase
    end

    logic                 vld_p0_q, vld_p1_q;
    logic signed [PW-1:0] prod1_p0_q, prod2_p0_q, prod3_p0_q, prod4_p0_q;
    logic signed [SW-1:0] sum_p0_d;
    logic [CHANNEL_WIDTH-1:0] pix_p1_q;
    logic [CHANNEL_WIDTH-1:0] mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W:0]       occ;
    logic                 accept, fifo_wr, fifo_rd;

    assign occ       = (CNT_W+1)'(count_q) + (CNT_W+1)'(vld_p0_q) + (CNT_W+1)'(vld_p1_q);
    assign in_ready  = occ < (CNT_W+1)'(OUT_DEPTH);
    assign accept    = in_valid && in_ready;
    assign out_valid = count_q != '0;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_wr   = vld_p1_q;
    assign fifo_rd   = out_valid && out_ready;

    // Stage A: per-row weighted products
    always_ff @(posedge clk) begin
        prod1_p0_q <= PW'(inner_product1) * PW'(c1);
        prod2_p0_q <= PW'(inner_product2) * PW'(c2);
        prod3_p0_q <= PW'(inner_product3) * PW'(c3);
        prod4_p0_q <= PW'(inner_product4) * PW'(c4);
    end

    assign sum_p0_d = SW'(prod1_p0_q) + SW'(prod2_p0_q) + SW'(prod3_p0_q) + SW'(prod4_p0_q);

    // Stage B: accumulate, round, clamp
    always_ff @(posedge clk) begin
        pix_p1_q <= round_clamp(sum_p0_d);
    end

    // Output FIFO storage; the credit rule guarantees a write never lands on a full buffer
    always_ff @(posedge clk) begin
        if (fifo_wr)
            mem_q[wr_ptr_q] <= pix_p1_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_wr)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (fifo_rd)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (fifo_wr && !fifo_rd)
            count_d = count_q + 1'b1;
        else if (!fifo_wr && fifo_rd)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_p0_q <= accept;
            vld_p1_q <= vld_p0_q;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: doc/bicubic_vreduce_stage2.md
# bicubic_vreduce_stage2

Second (vertical) reduction stage of the bicubic upscaler. Consumes the four row inner products produced by the horizontal weight-vector × pixel-matrix stage, weights them with a vertical phase coefficient set, then rounds and clamps each result to one output channel value. Results are buffered in a small output FIFO with a valid/ready handshake toward the pixel packer.

## Interface
- CHANNEL_WIDTH, 8, output channel width; the clamp ceiling is 2^CHANNEL_WIDTH−1.
- INTER_PRODUCT_WIDTH, 24, width of each signed inner-product input.
- FRAC_BITS, 14, right shift applied after accumulation (7 horizontal + 7 vertical).
- OUT_DEPTH, 4, output FIFO depth (power of two, ≥2).
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  the inner-product set and weight code are valid.
- in_ready  out  1  block can accept a set this cycle.
- w_code  in  3  vertical phase code.
- inner_product1..inner_product4  in  INTER_PRODUCT_WIDTH each  signed row inner products, row 1 at top.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  CHANNEL_WIDTH  clamped pixel value.

## Operation
- A set is accepted on a rising edge where in_valid && in_ready are both high.
- Coefficient table (signed, sum 128): code 0 → {0,128,0,0}; code 1 → {−9,111,29,−3}; code 2 → {−8,72,72,−8}; code 3 → {−3,29,111,−9}.
- Codes 4–7 are reserved and decode as code 0.
- Stage A registers four signed products ip_i × c_i, each INTER_PRODUCT_WIDTH+8 bits wide.
- Stage B sums the four products at INTER_PRODUCT_WIDTH+10 bits, adds 2^(FRAC_BITS−1), then shifts right arithmetically by FRAC_BITS.
- Stage B clamps the result: negative → 0; above 2^CHANNEL_WIDTH−1 → 2^CHANNEL_WIDTH−1. The clamped value is registered with a valid bit.
- Stage B output is written into the FIFO one edge later. The FIFO is a circular buffer with wrapping read/write pointers and an occupancy count of 0..OUT_DEPTH.
- Credit rule: in_ready = (fifo_count + inflight) < OUT_DEPTH, where inflight is the number of valid Stage A/B entries. Stages never stall; the credit rule guarantees no FIFO overflow.
- A FIFO write and read in the same cycle leave the count unchanged. This holds when full and when empty, including the case where a write arrives while the FIFO is empty and out_ready is high.
- Results leave in strict acceptance order.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0. Stage valid bits, FIFO pointers and count are all 0.
- Reset asserted mid-operation discards all in-flight and buffered data immediately. No partial results appear after release.
- Latency: a set accepted at edge k is visible on out_data with out_valid=1 after edge k+2, provided the FIFO was empty.
- Throughput: one set per cycle while out_ready is held high.
- out_data reflects the FIFO head combinationally from the registered array. It holds stable while out_valid && !out_ready.
- in_ready is combinational from registered state only. It does not depend on in_valid or out_ready.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, out_data=0. Assert rst_n low mid-burst: out_valid drops at once and the FIFO is empty after release.
- Code 0, ip={0,12800,0,0} → 100, visible after edge k+2. Code 2, all ip=25600 → 200. Code 6 with ip2=12800 → 100 (reserved code decodes as code 0).
- Rounding at code 0: ip2=63 → 0, ip2=64 → 1, ip2=127 → 1.
- Clamping at code 2: ip={32640,0,0,32640} → 0; ip={0,32640,32640,0} → 255.
- Backpressure: out_ready=0 with in_valid held high. in_ready drops after exactly 4 accepts. Then out_ready=1: 4 values drain in order, in_ready returns, and no data is lost or duplicated.
- Random in_valid/out_ready over 10k sets, compared against a reference model including codes 1 and 3. Includes same-cycle write+read at empty and at full.
